cmp_window_counter: RTL and testbench

CMP_WINDOW_COUNTER -- requirements
Module: cmp_window_counter

---
 rtl/cmp_window_counter.sv | 134 +++++++++++++
 tb/tb_cmp_window_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_counter.sv
// Counts compare-result flags (gt/eq/lt) over a window of win_len valid samples; result registered on the edge accepting the last sample.
// Backpressure: the result is held in DONE until out_ready; start during DONE+out_ready chains the next window.
module cmp_window_counter #(
    parameter int WIN_W = 4,
    parameter int CNT_W = WIN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             in_valid,
    input  logic             greater,
    input  logic             equal,
    input  logic             smaller,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_accept;
    logic             w_last;
    logic             w_onehot;
    logic [2:0]       w_flags;
    logic [CNT_W-1:0] w_len_in;
    logic [CNT_W-1:0] w_smp_inc;

    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_smp_cnt;
    logic [CNT_W-1:0] r_gt;
    logic [CNT_W-1:0] r_eq;
    logic [CNT_W-1:0] r_lt;
    logic             r_err;
    logic             r_out_valid;
    logic             r_busy;

    // A zero length encodes the full 2^WIN_W window.
    assign w_len_in  = (win_len == '0) ? (CNT_W'(1) << WIN_W) : CNT_W'(win_len);
    assign w_flags   = {greater, equal, smaller};
    assign w_onehot  = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
    assign w_accept  = (r_state == RUN) && in_valid;
    assign w_smp_inc = r_smp_cnt + CNT_W'(1);
    assign w_last    = w_accept && (w_smp_inc == r_len);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        w_state_nxt = RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_smp_cnt <= '0;
            r_gt      <= '0;
            r_eq      <= '0;
            r_lt      <= '0;
            r_err     <= 1'b0;
        end else if (w_load) begin
            r_len     <= w_len_in;
            r_smp_cnt <= '0;
            r_gt      <= '0;
            r_eq      <= '0;
            r_lt      <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_smp_cnt <= w_smp_inc;
            if (w_onehot) begin
                if (greater) r_gt <= r_gt + CNT_W'(1);
                if (equal)   r_eq <= r_eq + CNT_W'(1);
                if (smaller) r_lt <= r_lt + CNT_W'(1);
            end else begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign gt_cnt    = r_gt;
    assign eq_cnt    = r_eq;
    assign lt_cnt    = r_lt;
    assign err       = r_err;

endmodule

// File: tb/tb_cmp_window_counter.sv
// Self-checking bench for cmp_window_counter: directed vector table, corner sequences, random traffic vs a window model.
module tb_cmp_window_counter;

    localparam int WIN_W = 4;
    localparam int CNT_W = WIN_W + 1;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, greater, equal, smaller, out_ready;
    logic [WIN_W-1:0] win_len;
    logic             out_valid, err, busy;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // window model: sample list length and per-class tallies
    bit m_run, m_done, m_cnt_def, m_err;
    int m_len, m_n, m_gt, m_eq, m_lt;

    cmp_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .greater(greater), .equal(equal), .smaller(smaller),
        .out_ready(out_ready), .out_valid(out_valid), .gt_cnt(gt_cnt),
        .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_open(input logic [3:0] wl);
        m_run = 1; m_done = 0; m_cnt_def = 1;
        m_len = (wl == 0) ? (1 << WIN_W) : int'(wl);
        m_n = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
    endtask

    task automatic m_update(input bit r, input bit st, input logic [3:0] wl, input bit iv,
                            input logic [2:0] f, input bit ordy);
        if (r) begin
            m_run = 0; m_done = 0; m_cnt_def = 1;
            m_n = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
        end else if (m_done) begin
            if (ordy) begin
                m_done = 0;
                m_cnt_def = 0;
                if (st) m_open(wl);
            end
        end else if (m_run) begin
            if (iv) begin
                m_n++;
                if ($countones(f) == 1) begin
                    if (f[2]) m_gt++;
                    if (f[1]) m_eq++;
                    if (f[0]) m_lt++;
                end else begin
                    m_err = 1;
                end
                if (m_n == m_len) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end else if (st) begin
            m_open(wl);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input bit r, input bit st, input logic [3:0] wl, input bit iv,
                       input logic [2:0] f, input bit ordy);
        rst = r; start = st; win_len = wl; in_valid = iv;
        {greater, equal, smaller} = f; out_ready = ordy;
        @(posedge clk);
        #1;
        m_update(r, st, wl, iv, f, ordy);
        chk("out_valid", int'(out_valid), int'(m_done));
        chk("busy", int'(busy), int'(m_run));
        if (m_cnt_def) begin
            chk("gt_cnt", int'(gt_cnt), m_gt);
            chk("eq_cnt", int'(eq_cnt), m_eq);
            chk("lt_cnt", int'(lt_cnt), m_lt);
            chk("err", int'(err), int'(m_err));
        end
    endtask

    typedef struct {
        bit         r, st;
        logic [3:0] wl;
        bit         iv;
        logic [2:0] f;
        bit         ordy;
        bit         ov, bz;
        int         gt, eq, lt;
        bit         er;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // r st wl iv flags(g,e,s) ordy | ov bz gt eq lt err
        tbl[0]  = '{0, 1, 4'd4, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 4'd4, 1, 3'b100, 0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 4'd4, 1, 3'b010, 0, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 4'd4, 1, 3'b001, 0, 0, 1, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 4'd4, 1, 3'b100, 0, 1, 0, 2, 1, 1, 0};
        tbl[5]  = '{0, 0, 4'd4, 1, 3'b100, 0, 1, 0, 2, 1, 1, 0};
        tbl[6]  = '{0, 1, 4'd2, 0, 3'b000, 0, 1, 0, 2, 1, 1, 0};
        tbl[7]  = '{0, 0, 4'd4, 0, 3'b000, 1, 0, 0, 2, 1, 1, 0};
        tbl[8]  = '{0, 0, 4'd4, 1, 3'b100, 1, 0, 0, 2, 1, 1, 0};
        tbl[9]  = '{0, 1, 4'd3, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 4'd3, 1, 3'b100, 0, 0, 1, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 4'd3, 1, 3'b101, 0, 0, 1, 1, 0, 0, 1};
        tbl[12] = '{0, 0, 4'd3, 1, 3'b000, 0, 1, 0, 1, 0, 0, 1};
        tbl[13] = '{0, 1, 4'd2, 0, 3'b000, 1, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 4'd9, 1, 3'b010, 0, 0, 1, 0, 1, 0, 0};
        tbl[15] = '{0, 1, 4'd9, 1, 3'b001, 0, 1, 0, 0, 1, 1, 0};
        tbl[16] = '{0, 0, 4'd0, 0, 3'b000, 1, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{1, 1, 4'd5, 1, 3'b100, 1, 0, 0, 0, 0, 0, 0};

        cyc(1, 0, 4'd0, 0, 3'b000, 0);
        cyc(1, 0, 4'd0, 0, 3'b000, 0);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].r, tbl[i].st, tbl[i].wl, tbl[i].iv, tbl[i].f, tbl[i].ordy);
            chk($sformatf("tbl%0d.out_valid", i), int'(out_valid), int'(tbl[i].ov));
            chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].bz));
            if (tbl[i].ov || tbl[i].bz || tbl[i].r) begin
                chk($sformatf("tbl%0d.gt", i), int'(gt_cnt), tbl[i].gt);
                chk($sformatf("tbl%0d.eq", i), int'(eq_cnt), tbl[i].eq);
                chk($sformatf("tbl%0d.lt", i), int'(lt_cnt), tbl[i].lt);
                chk($sformatf("tbl%0d.err", i), int'(err), int'(tbl[i].er));
            end
        end

        // Full 16-sample window with idle gaps; DONE only after the 16th sample.
        cyc(0, 1, 4'd0, 0, 3'b000, 0);
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 1) cyc(0, 0, 4'd0, 0, 3'b010, 0);
            cyc(0, 0, 4'd0, 1, 3'b010, 0);
            if (i == 14) chk("w16.ov_before_last", int'(out_valid), 0);
        end
        chk("w16.ov", int'(out_valid), 1);
        chk("w16.eq", int'(eq_cnt), 16);
        chk("w16.gt", int'(gt_cnt), 0);
        chk("w16.lt", int'(lt_cnt), 0);
        cyc(0, 0, 4'd0, 0, 3'b000, 1);

        // Result held under backpressure, then chained start.
        cyc(0, 1, 4'd1, 0, 3'b000, 0);
        cyc(0, 0, 4'd1, 1, 3'b001, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, i[0], 4'd7, 1, 3'b100, 0);
            chk("hold.ov", int'(out_valid), 1);
            chk("hold.lt", int'(lt_cnt), 1);
            chk("hold.gt", int'(gt_cnt), 0);
        end
        cyc(0, 1, 4'd2, 0, 3'b000, 1);
        chk("chain.busy", int'(busy), 1);
        chk("chain.lt", int'(lt_cnt), 0);
        cyc(0, 0, 4'd2, 1, 3'b100, 0);
        cyc(0, 0, 4'd2, 1, 3'b100, 0);
        chk("chain.ov", int'(out_valid), 1);
        chk("chain.gt", int'(gt_cnt), 2);
        cyc(0, 0, 4'd0, 0, 3'b000, 1);

        // Reset mid-run discards the partial window.
        cyc(0, 1, 4'd4, 0, 3'b000, 0);
        cyc(0, 0, 4'd4, 1, 3'b100, 0);
        cyc(0, 0, 4'd4, 1, 3'b010, 0);
        cyc(1, 0, 4'd4, 1, 3'b100, 1);
        chk("rst.gt", int'(gt_cnt), 0);
        chk("rst.busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 4'd4, 1, 3'b100, 0);
            chk("rst.no_ov", int'(out_valid), 0);
        end
        cyc(0, 1, 4'd4, 0, 3'b000, 0);
        cyc(0, 0, 4'd4, 1, 3'b001, 0);
        cyc(0, 0, 4'd4, 1, 3'b001, 0);
        cyc(0, 0, 4'd4, 1, 3'b100, 0);
        cyc(0, 0, 4'd4, 1, 3'b010, 0);
        chk("fresh.ov", int'(out_valid), 1);
        chk("fresh.lt", int'(lt_cnt), 2);
        chk("fresh.gt", int'(gt_cnt), 1);
        chk("fresh.eq", int'(eq_cnt), 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] f;
            if ($urandom_range(0, 3) == 0) f = 3'($urandom);
            else f = 3'b001 << $urandom_range(0, 2);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                $urandom_range(0, 3) != 0, f, $urandom_range(0, 1) == 1);
            if (m_done) begin
                n_chk++;
                if ((m_err && (int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt) > m_len)) ||
                    (!m_err && (int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt) != m_len))) begin
                    n_fail++;
                    $display("FAIL sum_invariant: got %0d window %0d",
                             int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt), m_len);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
